// File: rtl/simon_pad.sv
// Player-side front end for the Simon game: button conditioning, single-press
// encoding for the game core, and the four-LED drive.
module simon_pad #(
    parameter int DEBOUNCE   = 3,
    parameter int MIN_PRESS  = 2,
    parameter int GAP        = 6,
    parameter int BLINK_HALF = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic [1:0] simonNum,
    input  logic       simonPressed,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic [3:0] led
);

    localparam int DB_W    = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W  = $clog2(MIN_PRESS + 1);
    localparam int GAP_W   = $clog2(GAP + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    function automatic logic [3:0] oneHot(input logic [1:0] n);
        logic [3:0] v;
        case (n)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            2'd3:    v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    function automatic logic singleBit(input logic [3:0] v);
        logic r;
        case (v)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] bitIndex(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [3:0]             sync1_r;
    logic [3:0]             sync2_r;
    logic [3:0]             db_r;
    logic [3:0][DB_W-1:0]   dbCnt_r;
    state_t                 state_r;
    state_t                 stateNext_s;
    logic [HOLD_W-1:0]      holdCnt_r;
    logic [HOLD_W-1:0]      holdCntNext_s;
    logic [GAP_W-1:0]       gapCnt_r;
    logic [GAP_W-1:0]       gapCntNext_s;
    logic [GAP_W-1:0]       gapInc_s;
    logic [1:0]             playerNum_r;
    logic [1:0]             playerNumNext_s;
    logic                   playerPressed_r;
    logic                   playerPressedNext_s;
    logic                   accBit_s;
    logic                   holdDone_s;
    logic [BLINK_W-1:0]     blinkCnt_r;
    logic                   blinkPhase_r;
    logic [3:0]             led_r;
    logic [3:0]             ledNext_s;

    assign playerNum     = playerNum_r;
    assign playerPressed = playerPressed_r;
    assign led           = led_r;

    // Two-flop synchronizer and per-bit debounce; a sample matching db restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
            db_r    <= 4'b0000;
            dbCnt_r <= '0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    dbCnt_r[i] <= '0;
                end else if (dbCnt_r[i] == DB_W'(DEBOUNCE - 1)) begin
                    db_r[i]    <= sync2_r[i];
                    dbCnt_r[i] <= '0;
                end else begin
                    dbCnt_r[i] <= dbCnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    assign accBit_s   = db_r[playerNum_r];
    assign holdDone_s = (holdCnt_r >= HOLD_W'(MIN_PRESS - 1));
    assign gapInc_s   = (gapCnt_r == GAP_W'(GAP)) ? gapCnt_r : gapCnt_r + GAP_W'(1);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic; aborts in PRESS take priority over a normal release.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (singleBit(db_r) && !simonTurn && !gameOver) stateNext_s = PRESS;
                else                                            stateNext_s = IDLE;
            end
            PRESS: begin
                if (simonTurn || gameOver)        stateNext_s = LOCKOUT;
                else if (!accBit_s && holdDone_s) stateNext_s = RELEASE;
                else                              stateNext_s = PRESS;
            end
            RELEASE: stateNext_s = LOCKOUT;
            LOCKOUT: begin
                if ((gapInc_s >= GAP_W'(GAP)) && (db_r == 4'b0000)) stateNext_s = IDLE;
                else                                                 stateNext_s = LOCKOUT;
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // Output/datapath next values; playerNum only changes on the accepting edge.
    always_comb begin
        playerNumNext_s     = playerNum_r;
        playerPressedNext_s = playerPressed_r;
        holdCntNext_s       = holdCnt_r;
        gapCntNext_s        = gapCnt_r;
        case (state_r)
            IDLE: begin
                if (stateNext_s == PRESS) begin
                    playerNumNext_s     = bitIndex(db_r);
                    playerPressedNext_s = 1'b1;
                    holdCntNext_s       = '0;
                end else begin
                    playerPressedNext_s = 1'b0;
                end
            end
            PRESS: begin
                if (stateNext_s == LOCKOUT) begin
                    playerPressedNext_s = 1'b0;
                    gapCntNext_s        = '0;
                end else begin
                    playerPressedNext_s = 1'b1;
                    if (holdCnt_r != HOLD_W'(MIN_PRESS)) holdCntNext_s = holdCnt_r + HOLD_W'(1);
                    else                                 holdCntNext_s = holdCnt_r;
                end
            end
            RELEASE: begin
                playerPressedNext_s = 1'b0;
                gapCntNext_s        = '0;
            end
            LOCKOUT: begin
                playerPressedNext_s = 1'b0;
                gapCntNext_s        = gapInc_s;
            end
            default: playerPressedNext_s = 1'b0;
        endcase
    end

    // Registered player outputs and FSM counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            playerNum_r     <= 2'd0;
            playerPressed_r <= 1'b0;
            holdCnt_r       <= '0;
            gapCnt_r        <= '0;
        end else begin
            playerNum_r     <= playerNumNext_s;
            playerPressed_r <= playerPressedNext_s;
            holdCnt_r       <= holdCntNext_s;
            gapCnt_r        <= gapCntNext_s;
        end
    end

    // Game-over blink timer; held cleared whenever gameOver is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blinkCnt_r   <= '0;
            blinkPhase_r <= 1'b0;
        end else if (!gameOver) begin
            blinkCnt_r   <= '0;
            blinkPhase_r <= 1'b0;
        end else if (blinkCnt_r == BLINK_W'(BLINK_HALF - 1)) begin
            blinkCnt_r   <= '0;
            blinkPhase_r <= ~blinkPhase_r;
        end else begin
            blinkCnt_r   <= blinkCnt_r + BLINK_W'(1);
            blinkPhase_r <= blinkPhase_r;
        end
    end

    // LED source priority: game over, then Simon's demo, then the player.
    always_comb begin
        ledNext_s = 4'b0000;
        if (gameOver) begin
            ledNext_s = blinkPhase_r ? 4'b1111 : 4'b0000;
        end else if (simonTurn) begin
            ledNext_s = simonPressed ? oneHot(simonNum) : 4'b0000;
        end else if (playerPressed_r) begin
            ledNext_s = oneHot(playerNum_r);
        end else begin
            ledNext_s = 4'b0000;
        end
    end

    // LED output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r <= 4'b0000;
        end else begin
            led_r <= ledNext_s;
        end
    end

endmodule

// File: doc/simon_pad.md
Name: simon_pad

Overview:
- Player-side front end for the Simon game block.
- Debounces four raw push-buttons and encodes a single accepted press into the playerNum/playerPressed pair that the game consumes.
- Guarantees playerNum is stable for the whole time playerPressed is high.
- Drives four LEDs: Simon's demonstrated presses during its turn, the player's press otherwise, and a blink pattern on game over.

Parameters:
- DEBOUNCE, 3: consecutive stable synchronized samples needed to change a debounced button bit.
- MIN_PRESS, 2: minimum cycles playerPressed stays high once asserted.
- GAP, 6: lockout cycles after a release before a new press is accepted.
- BLINK_HALF, 30: half-period in cycles of the game-over blink (0.5 s at 60 Hz).

Ports:
- clk  in  1  system clock, 60 Hz.
- reset  in  1  asynchronous, active-low reset; the block is in reset while reset=0.
- btn  in  4  raw buttons, active-high, asynchronous to clk; btn[i] means number i.
- simonTurn  in  1  game is demonstrating; player input is blocked.
- simonNum  in  2  number Simon is showing.
- simonPressed  in  1  Simon's virtual button is down.
- gameOver  in  1  game lost; sticky until game reset.
- playerNum  out  2  encoded number of the accepted button.
- playerPressed  out  1  accepted button is held.
- led  out  4  one-hot LED drive.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - Synchronizers, debounced bits, counters and blink phase are 0.
  - FSM goes to IDLE.
- Input conditioning:
  - Each btn bit passes a 2-flop synchronizer.
  - The debounced bit db[i] takes the synchronized value after DEBOUNCE consecutive cycles that differ from the current db[i].
  - Any sample equal to db[i] clears that bit's counter.
  - Counter width is clog2(DEBOUNCE+1).
- FSM states: IDLE, PRESS, RELEASE, LOCKOUT.
- IDLE:
  - Accepts a press when exactly one db bit is 1, simonTurn=0 and gameOver=0.
  - On the same edge: playerNum <= index of that bit, playerPressed <= 1, hold counter <= 0, next state PRESS.
  - Zero db bits or two or more db bits: no action.
- PRESS:
  - Hold counter increments each cycle and saturates at MIN_PRESS.
  - playerNum is frozen. Other buttons pressed meanwhile are ignored and do not change playerNum.
  - Leave to RELEASE when the accepted bit's db is 0 and the hold counter >= MIN_PRESS-1. This gives at least MIN_PRESS cycles high.
  - If the accepted bit releases earlier, playerPressed stays high until MIN_PRESS cycles have elapsed.
  - Abort: simonTurn=1 or gameOver=1 while in PRESS → playerPressed <= 0 next edge, go to LOCKOUT.
- RELEASE:
  - playerPressed <= 0, gap counter <= 0, next state LOCKOUT.
  - The game sees exactly one falling edge per accepted press.
- LOCKOUT:
  - Gap counter increments.
  - Go to IDLE only when the counter has reached GAP and all db bits are 0.
  - A button still held keeps the block in LOCKOUT indefinitely, so one physical press never yields two presses.
- Latency:
  - Raw btn rise (stable) to playerPressed=1 is DEBOUNCE+3 clk edges.
  - Raw release to playerPressed=0 is DEBOUNCE+4 edges, subject to MIN_PRESS.
- LED priority, registered with 1-cycle latency:
  1. gameOver=1: led = 4'b1111 when blink phase=1, else 0. The blink counter runs only while gameOver=1 and toggles the phase every BLINK_HALF cycles. On gameOver=0 the counter and phase clear.
  2. simonTurn=1: led = simonPressed ? onehot(simonNum) : 0.
  3. playerPressed=1: led = onehot(playerNum).
  4. Otherwise led = 0.
- Simultaneous events:
  - An IDLE accept condition together with simonTurn rising on the same edge is rejected, because simonTurn is evaluated on that edge.
  - gameOver overrides every other LED source immediately, with 1-cycle latency.
- Reset mid-press: playerPressed drops asynchronously. After release of reset, a still-held button must re-debounce and is accepted as a new press only after DEBOUNCE+3 edges.

Test Plan:
- Reset, then btn=4'b0100 held 10 cycles, simonTurn=0 → playerPressed rises at edge 6 after the first sampling edge, playerNum=2, led=4'b0100. Release → playerPressed falls 7 edges later; IDLE is reached 6 cycles after that.
- btn[1] glitches high for 2 cycles (less than DEBOUNCE) → playerPressed stays 0 and led stays 0 throughout.
- btn=4'b0011 pressed simultaneously → no press. Then btn[0] releases and btn[1] is held → press accepted with playerNum=1. While held, assert btn[3] → playerNum stays 1.
- Press btn[0] and raise simonTurn mid-press → playerPressed=0 next edge, no second press while btn[0] is held. With simonTurn=1, simonNum=3, simonPressed=1 → led=4'b1000; simonPressed=0 → led=0.
- gameOver=1 with a button held → playerPressed=0 and led toggles between 4'b1111 and 0 every 30 cycles. gameOver=0 → led=0 and the blink phase is cleared.
- Assert reset=0 during a held press → all outputs 0 immediately. Deassert with the button still held → new press after DEBOUNCE+3 edges, playerNum equal to the held button.
